// File: rtl/exe2mem_fifo.sv
// EXE-to-MEM result queue: selects shifter or ALU result at push and buffers it with its
// writeback/memory control fields in a circular buffer with synchronous flush.
module exe2mem_fifo #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32,
    parameter int REG_W  = 6
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [DATA_W-1:0]          DOUT_SE,
    input  logic [DATA_W-1:0]          ALU_RES_RE,
    input  logic                       SEL_SHIFT_RE,
    input  logic [REG_W-1:0]           DEST_RE,
    input  logic                       WB_RE,
    input  logic                       LOAD_RE,
    input  logic                       STORE_RE,
    input  logic [1:0]                 SIZE_RE,
    input  logic [DATA_W-1:0]          STORE_DATA_RE,
    input  logic                       VALID_RE,
    output logic                       READY_RE,
    input  logic                       FLUSH_RE,
    input  logic                       POP_RM,
    output logic                       VALID_RM,
    output logic [DATA_W-1:0]          RES_RM,
    output logic [REG_W-1:0]           DEST_RM,
    output logic                       WB_RM,
    output logic                       LOAD_RM,
    output logic                       STORE_RM,
    output logic [1:0]                 SIZE_RM,
    output logic [DATA_W-1:0]          STORE_DATA_RM,
    output logic [$clog2(DEPTH):0]     COUNT_RM
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [DATA_W-1:0] res;
        logic [REG_W-1:0]  dest;
        logic              wb;
        logic              load;
        logic              store;
        logic [1:0]        size;
        logic [DATA_W-1:0] store_data;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            push;
    logic            pop;

    // Ready looks only at registered occupancy, so MEM's pop never reaches back into EXE.
    assign READY_RE = !RESET && (count != CW'(DEPTH));
    assign VALID_RM = (count != '0);
    assign push     = VALID_RE && READY_RE;
    assign pop      = POP_RM && VALID_RM;

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= '{res:        SEL_SHIFT_RE ? DOUT_SE : ALU_RES_RE,
                             dest:       DEST_RE,
                             wb:         WB_RE,
                             load:       LOAD_RE,
                             store:      STORE_RE,
                             size:       SIZE_RE,
                             store_data: STORE_DATA_RE};
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET || FLUSH_RE) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Empty queue shows all-zero outputs rather than whatever entry rd_ptr last held.
    assign head          = VALID_RM ? mem[rd_ptr] : '0;
    assign RES_RM        = head.res;
    assign DEST_RM       = head.dest;
    assign WB_RM         = head.wb;
    assign LOAD_RM       = head.load;
    assign STORE_RM      = head.store;
    assign SIZE_RM       = head.size;
    assign STORE_DATA_RM = head.store_data;
    assign COUNT_RM      = count;

endmodule
